round_controller: RTL and testbench

ROUND_CONTROLLER -- requirements
Module: round_controller

---
 rtl/round_controller_if.sv | 46 ++++
 rtl/round_controller.sv | 214 +++++++++++++++++++++
 tb/tb_round_controller.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/round_controller_if.sv
// round_controller_if
//   Groups the player handshake, game-core operand/verdict signals and match
//   status of round_controller into one bundle.
//   slave  : the round controller (drives Ready, operands, scores, status)
//   master : players / game core / host (drive Start, guesses, Result)
//   Signals:
//     Start                      begin a match
//     P1_Guess/P1_Valid/P1_Ready player-1 guess handshake
//     P2_Guess/P2_Valid/P2_Ready player-2 guess handshake
//     Result                     game-core verdict (10 P1, 01 P2, 11 tie, 00 none)
//     First_Num/Second_Num/Target_Num  operands presented to the game core
//     Score1/Score2              match scores
//     Round_Done                 one-cycle pulse per scored round
//     Match_Over/Champion        match finished / winner (10 P1, 01 P2)
interface round_controller_if #(
  parameter int size = 6
);
  logic            Start;
  logic [size-1:0] P1_Guess;
  logic            P1_Valid;
  logic            P1_Ready;
  logic [size-1:0] P2_Guess;
  logic            P2_Valid;
  logic            P2_Ready;
  logic [1:0]      Result;
  logic [size-1:0] First_Num;
  logic [size-1:0] Second_Num;
  logic [size-1:0] Target_Num;
  logic [3:0]      Score1;
  logic [3:0]      Score2;
  logic            Round_Done;
  logic            Match_Over;
  logic [1:0]      Champion;

  modport slave (
    input  Start, P1_Guess, P1_Valid, P2_Guess, P2_Valid, Result,
    output P1_Ready, P2_Ready, First_Num, Second_Num, Target_Num,
           Score1, Score2, Round_Done, Match_Over, Champion
  );

  modport master (
    output Start, P1_Guess, P1_Valid, P2_Guess, P2_Valid, Result,
    input  P1_Ready, P2_Ready, First_Num, Second_Num, Target_Num,
           Score1, Score2, Round_Done, Match_Over, Champion
  );
endinterface

// File: rtl/round_controller.sv
// round_controller
//   Runs a match of guessing rounds between two players. Each round collects
//   one guess from each player, presents both guesses plus a pseudo-random
//   target to an external game core, waits Settle_Cycles for the core to
//   settle, samples its verdict once and updates the scores. The first
//   player to reach Win_Score ends the match.
//   Ports:
//     Clock  single clock, rising edge
//     Reset  synchronous, active-high
//     bus    round_controller_if.slave (handshake, operands, scores, status)
//   Parameters:
//     size           width of guesses and target
//     Settle_Cycles  cycles operands are held before Result is sampled (1..15)
//     Win_Score      score that ends the match (1..15)
module round_controller #(
  parameter int size          = 6,
  parameter int Settle_Cycles = 4,
  parameter int Win_Score     = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  round_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    PRESENT,
    WAIT,
    SCORE,
    DONE
  } state_t;

  localparam logic [3:0]  SETTLE_LAST = 4'(Settle_Cycles - 1);
  localparam logic [3:0]  WIN         = 4'(Win_Score);
  localparam logic [3:0]  SCORE_MAX   = 4'd15;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;

  state_t          state;
  logic [15:0]     lfsr;
  logic [3:0]      wait_cnt;

  logic            p1_held;
  logic            p2_held;
  logic [size-1:0] p1_guess_q;
  logic [size-1:0] p2_guess_q;

  logic [size-1:0] first_q;
  logic [size-1:0] second_q;
  logic [size-1:0] target_q;
  logic [3:0]      score1_q;
  logic [3:0]      score2_q;
  logic            p1_ready_q;
  logic            p2_ready_q;
  logic            round_done_q;
  logic            match_over_q;
  logic [1:0]      champion_q;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting left with feedback into bit 0.
  // From a non-zero seed this sequence never reaches zero.
  logic lfsr_fb;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Ready is only ever high in COLLECT for a player not yet captured, so the
  // registered Ready doubles as the "accept this cycle" qualifier.
  logic p1_take;
  logic p2_take;
  logic p1_have;
  logic p2_have;
  assign p1_take = bus.P1_Valid & p1_ready_q;
  assign p2_take = bus.P2_Valid & p2_ready_q;
  assign p1_have = p1_held | p1_take;
  assign p2_have = p2_held | p2_take;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      lfsr         <= LFSR_SEED;
      wait_cnt     <= '0;
      p1_held      <= 1'b0;
      p2_held      <= 1'b0;
      p1_guess_q   <= '0;
      p2_guess_q   <= '0;
      first_q      <= '0;
      second_q     <= '0;
      target_q     <= '0;
      score1_q     <= '0;
      score2_q     <= '0;
      p1_ready_q   <= 1'b0;
      p2_ready_q   <= 1'b0;
      round_done_q <= 1'b0;
      match_over_q <= 1'b0;
      champion_q   <= '0;
    end else begin
      lfsr         <= {lfsr[14:0], lfsr_fb};
      round_done_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.Start) begin
            state      <= COLLECT;
            score1_q   <= '0;
            score2_q   <= '0;
            p1_held    <= 1'b0;
            p2_held    <= 1'b0;
            p1_ready_q <= 1'b1;
            p2_ready_q <= 1'b1;
          end
        end

        COLLECT: begin
          if (p1_take) begin
            p1_guess_q <= bus.P1_Guess;
            p1_held    <= 1'b1;
          end
          if (p2_take) begin
            p2_guess_q <= bus.P2_Guess;
            p2_held    <= 1'b1;
          end
          p1_ready_q <= ~p1_have;
          p2_ready_q <= ~p2_have;
          // Leave on the same edge that captures the last outstanding guess,
          // so PRESENT is the cycle right after both guesses are held.
          if (p1_have && p2_have) begin
            state <= PRESENT;
          end
        end

        PRESENT: begin
          first_q  <= p1_guess_q;
          second_q <= p2_guess_q;
          target_q <= lfsr[size-1:0];
          wait_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          if (wait_cnt == SETTLE_LAST) begin
            wait_cnt <= '0;
            state    <= SCORE;
            // The verdict is looked at on this edge only; scores and the
            // Round_Done pulse become visible during SCORE.
            case (bus.Result)
              2'b10: begin
                if (score1_q != SCORE_MAX) begin
                  score1_q <= score1_q + 4'd1;
                end
                round_done_q <= 1'b1;
              end
              2'b01: begin
                if (score2_q != SCORE_MAX) begin
                  score2_q <= score2_q + 4'd1;
                end
                round_done_q <= 1'b1;
              end
              2'b11: begin
                round_done_q <= 1'b1;
              end
              default: begin
                // No decision: round is replayed without scoring.
              end
            endcase
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        SCORE: begin
          if ((score1_q == WIN) || (score2_q == WIN)) begin
            state        <= DONE;
            match_over_q <= 1'b1;
            champion_q   <= (score1_q == WIN) ? 2'b10 : 2'b01;
          end else begin
            state      <= COLLECT;
            p1_held    <= 1'b0;
            p2_held    <= 1'b0;
            p1_ready_q <= 1'b1;
            p2_ready_q <= 1'b1;
          end
        end

        DONE: begin
          if (bus.Start) begin
            state        <= COLLECT;
            score1_q     <= '0;
            score2_q     <= '0;
            match_over_q <= 1'b0;
            champion_q   <= '0;
            p1_held      <= 1'b0;
            p2_held      <= 1'b0;
            p1_ready_q   <= 1'b1;
            p2_ready_q   <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.P1_Ready   = p1_ready_q;
  assign bus.P2_Ready   = p2_ready_q;
  assign bus.First_Num  = first_q;
  assign bus.Second_Num = second_q;
  assign bus.Target_Num = target_q;
  assign bus.Score1     = score1_q;
  assign bus.Score2     = score2_q;
  assign bus.Round_Done = round_done_q;
  assign bus.Match_Over = match_over_q;
  assign bus.Champion   = champion_q;

endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller
//   Directed bench for round_controller. A round-timeline model predicts
//   every output each cycle; a negedge process compares DUT against it, and
//   literal expectations at key points pin the model itself.
module tb_round_controller;

  localparam int SZ     = 6;
  localparam int SETTLE = 4;
  localparam int WIN    = 3;

  logic clk;
  logic rst;

  round_controller_if #(.size(SZ)) bus ();

  round_controller #(
    .size(SZ),
    .Settle_Cycles(SETTLE),
    .Win_Score(WIN)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Model: a match is idle, collecting, running a round, or done. A round is
  // a timeline counted from the capture edge: t=1 present, t=2..SETTLE+1
  // settle, verdict taken on the edge ending t=SETTLE+1, t=SETTLE+2 score.
  localparam int M_IDLE    = 0;
  localparam int M_COLLECT = 1;
  localparam int M_ROUND   = 2;
  localparam int M_DONE    = 3;

  logic          armed = 1'b0;
  int            m_mode;
  int            m_t;
  logic [15:0]   m_lfsr;
  logic          m_h1, m_h2;
  logic [SZ-1:0] m_g1, m_g2, m_first, m_second, m_target;
  int            m_s1, m_s2;
  logic          m_rd;
  logic [1:0]    m_champ;

  always @(posedge clk) begin
    armed <= 1'b1;
    m_rd  <= 1'b0;
    if (rst) begin
      m_lfsr   <= 16'hACE1;
      m_mode   <= M_IDLE;
      m_t      <= 0;
      m_h1     <= 1'b0;
      m_h2     <= 1'b0;
      m_g1     <= '0;
      m_g2     <= '0;
      m_first  <= '0;
      m_second <= '0;
      m_target <= '0;
      m_s1     <= 0;
      m_s2     <= 0;
      m_champ  <= 2'b00;
    end else begin
      m_lfsr <= lfsr_step(m_lfsr);
      case (m_mode)
        M_IDLE, M_DONE: begin
          if (bus.Start) begin
            m_mode  <= M_COLLECT;
            m_s1    <= 0;
            m_s2    <= 0;
            m_champ <= 2'b00;
            m_h1    <= 1'b0;
            m_h2    <= 1'b0;
          end
        end
        M_COLLECT: begin
          if (bus.P1_Valid && !m_h1) begin
            m_h1 <= 1'b1;
            m_g1 <= bus.P1_Guess;
          end
          if (bus.P2_Valid && !m_h2) begin
            m_h2 <= 1'b1;
            m_g2 <= bus.P2_Guess;
          end
          if ((m_h1 || bus.P1_Valid) && (m_h2 || bus.P2_Valid)) begin
            m_mode <= M_ROUND;
            m_t    <= 1;
          end
        end
        M_ROUND: begin
          m_t <= m_t + 1;
          if (m_t == 1) begin
            m_first  <= m_g1;
            m_second <= m_g2;
            m_target <= m_lfsr[SZ-1:0];
          end
          if (m_t == SETTLE + 1) begin
            if (bus.Result == 2'b10) begin
              if (m_s1 < 15) m_s1 <= m_s1 + 1;
              m_rd <= 1'b1;
            end else if (bus.Result == 2'b01) begin
              if (m_s2 < 15) m_s2 <= m_s2 + 1;
              m_rd <= 1'b1;
            end else if (bus.Result == 2'b11) begin
              m_rd <= 1'b1;
            end
          end
          if (m_t == SETTLE + 2) begin
            if (m_s1 == WIN || m_s2 == WIN) begin
              m_mode  <= M_DONE;
              m_champ <= (m_s1 == WIN) ? 2'b10 : 2'b01;
            end else begin
              m_mode <= M_COLLECT;
              m_h1   <= 1'b0;
              m_h2   <= 1'b0;
            end
          end
        end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("p1_ready",   32'(bus.P1_Ready),   32'((m_mode == M_COLLECT) && !m_h1));
      check("p2_ready",   32'(bus.P2_Ready),   32'((m_mode == M_COLLECT) && !m_h2));
      check("first_num",  32'(bus.First_Num),  32'(m_first));
      check("second_num", 32'(bus.Second_Num), 32'(m_second));
      check("target_num", 32'(bus.Target_Num), 32'(m_target));
      check("score1",     32'(bus.Score1),     32'(m_s1));
      check("score2",     32'(bus.Score2),     32'(m_s2));
      check("round_done", 32'(bus.Round_Done), 32'(m_rd));
      check("match_over", 32'(bus.Match_Over), 32'(m_mode == M_DONE));
      check("champion",   32'(bus.Champion),   32'(m_champ));
      if (bus.Round_Done === 1'b1) rd_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic play_round(input logic [SZ-1:0] g1, input logic [SZ-1:0] g2,
                            input logic [1:0] res, input logic [1:0] junk);
    bus.P1_Guess = g1;
    bus.P1_Valid = 1'b1;
    bus.P2_Guess = g2;
    bus.P2_Valid = 1'b1;
    tick();                      // capture -> present
    bus.P1_Valid = 1'b0;
    bus.P2_Valid = 1'b0;
    bus.Result   = junk;
    tick();                      // -> settle
    repeat (SETTLE - 1) tick();
    bus.Result = res;
    tick();                      // verdict taken -> score
    bus.Result = junk;
    tick();                      // -> collect or done
  endtask

  initial begin
    rst          = 1'b1;
    bus.Start    = 1'b0;
    bus.P1_Guess = '0;
    bus.P1_Valid = 1'b0;
    bus.P2_Guess = '0;
    bus.P2_Valid = 1'b0;
    bus.Result   = 2'b00;
    repeat (3) tick();
    check("rst_score1", 32'(bus.Score1), 32'd0);
    check("rst_ready",  32'({bus.P1_Ready, bus.P2_Ready}), 32'd0);
    check("rst_target", 32'(bus.Target_Num), 32'd0);

    // Simultaneous offers, verdict only in the sample cycle.
    rst       = 1'b0;
    bus.Start = 1'b1;
    tick();
    check("collect_ready", 32'({bus.P1_Ready, bus.P2_Ready}), 32'b11);
    bus.Start    = 1'b0;
    bus.P1_Guess = 6'd5;
    bus.P1_Valid = 1'b1;
    bus.P2_Guess = 6'd9;
    bus.P2_Valid = 1'b1;
    bus.Result   = 2'b01;
    tick();
    check("capture_ready", 32'({bus.P1_Ready, bus.P2_Ready}), 32'b00);
    bus.P1_Valid = 1'b0;
    bus.P2_Valid = 1'b0;
    tick();
    check("first_5",  32'(bus.First_Num),  32'd5);
    check("second_9", 32'(bus.Second_Num), 32'd9);
    check("target_7", 32'(bus.Target_Num), 32'd7);
    repeat (SETTLE - 1) tick();
    check("no_early_score", 32'(bus.Score2), 32'd0);
    bus.Result = 2'b10;
    tick();
    check("score1_1",   32'(bus.Score1),     32'd1);
    check("rd_pulse_1", 32'(bus.Round_Done), 32'd1);
    bus.Result = 2'b01;
    tick();
    check("rd_drop", 32'(bus.Round_Done), 32'd0);

    // Two more P1 wins end the match.
    play_round(6'd3, 6'd4, 2'b10, 2'b01);
    play_round(6'd63, 6'd0, 2'b10, 2'b01);
    check("win_over",   32'(bus.Match_Over), 32'd1);
    check("win_champ",  32'(bus.Champion),   32'b10);
    check("win_score1", 32'(bus.Score1),     32'd3);
    check("win_score2", 32'(bus.Score2),     32'd0);
    check("rd_count_3", 32'(rd_count),       32'd3);
    repeat (2) tick();

    // Restart from DONE.
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check("restart_scores", 32'({bus.Score1, bus.Score2}), 32'd0);
    check("restart_over",   32'(bus.Match_Over), 32'd0);
    check("restart_champ",  32'(bus.Champion),   32'd0);
    check("restart_ready",  32'(bus.P1_Ready),   32'd1);

    // No decision replays, then a tie.
    play_round(6'd1, 6'd2, 2'b00, 2'b11);
    check("nodec_rd",    32'(rd_count), 32'd3);
    check("nodec_ready", 32'({bus.P1_Ready, bus.P2_Ready}), 32'b11);
    play_round(6'd7, 6'd8, 2'b11, 2'b10);
    check("tie_rd",     32'(rd_count), 32'd4);
    check("tie_scores", 32'({bus.Score1, bus.Score2}), 32'd0);

    // Staggered offers with a repeated P1 offer.
    bus.P1_Guess = 6'd12;
    bus.P1_Valid = 1'b1;
    tick();
    bus.P1_Guess = 6'd33;
    repeat (4) tick();
    check("stagger_ready", 32'({bus.P1_Ready, bus.P2_Ready}), 32'b01);
    bus.P2_Guess = 6'd20;
    bus.P2_Valid = 1'b1;
    tick();
    bus.P1_Valid = 1'b0;
    bus.P2_Valid = 1'b0;
    tick();
    check("stagger_first",  32'(bus.First_Num),  32'd12);
    check("stagger_second", 32'(bus.Second_Num), 32'd20);
    repeat (SETTLE - 1) tick();
    bus.Result = 2'b01;
    tick();
    bus.Result = 2'b00;
    tick();
    play_round(6'd10, 6'd11, 2'b01, 2'b10);
    check("score2_2", 32'(bus.Score2), 32'd2);

    // Reset in the middle of the settle window.
    bus.P1_Valid = 1'b1;
    bus.P2_Valid = 1'b1;
    tick();
    bus.P1_Valid = 1'b0;
    bus.P2_Valid = 1'b0;
    repeat (2) tick();
    bus.Result = 2'b01;
    rst        = 1'b1;
    bus.Start  = 1'b1;
    tick();
    check("midrst_score2", 32'(bus.Score2),     32'd0);
    check("midrst_first",  32'(bus.First_Num),  32'd0);
    check("midrst_rd",     32'(bus.Round_Done), 32'd0);
    check("midrst_ready",  32'({bus.P1_Ready, bus.P2_Ready}), 32'd0);
    bus.Start = 1'b0;
    rst       = 1'b0;
    repeat (SETTLE + 2) tick();
    check("midrst_rd_count", 32'(rd_count), 32'd6);
    check("idle_ready",      32'(bus.P1_Ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
